// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the multi-direction traffic-light controller.
//   - tlc_state_e : controller state encoding
//   - LAMP_*      : per-direction lamp codes as seen by the lamp driver
//   - rr_next()   : round-robin search for the next direction with demand
// ---------------------------------------------------------------------------
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    FLASH  = 2'd3
  } tlc_state_e;

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Upper bound on directions; the search below is unrolled to this size and
  // masked by the real direction count.
  localparam int MAX_DIR = 8;

  // Returns the first direction after 'phase' (wrapping modulo num_dir) whose
  // demand bit is set. With no demand anywhere, the plain successor
  // phase+1 is returned, so a zero demand vector yields fixed round robin.
  // The search includes 'phase' itself as the last candidate.
  function automatic logic [2:0] rr_next(input logic [MAX_DIR-1:0] dem,
                                         input logic [2:0]         phase,
                                         input int                 num_dir);
    logic [2:0] sel;
    logic       found;
    int         idx;
    idx   = (int'(phase) + 1) % num_dir;
    sel   = idx[2:0];
    found = 1'b0;
    for (int k = 1; k <= MAX_DIR; k++) begin
      if ((k <= num_dir) && !found) begin
        idx = (int'(phase) + k) % num_dir;
        if (dem[idx[2:0]]) begin
          sel   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/tlc_timer.sv
// ---------------------------------------------------------------------------
// tlc_timer
// Loadable down-counter used as the per-state timer of the controller. It is
// also reloaded each flash half-period while the controller is flashing.
// The counter saturates at zero; it never wraps.
//
// Ports:
//   clk   in  1      clock
//   rst   in  1      asynchronous active-low reset (count <- RST_VAL)
//   load  in  1      load 'value' on the next edge (wins over counting)
//   value in  CNT_W  value to load
//   zero  out 1      count is zero
// ---------------------------------------------------------------------------
module tlc_timer
  import tlc_pkg::*;
#(
  parameter int               CNT_W   = 6,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/tlc_multi.sv
// ---------------------------------------------------------------------------
// tlc_multi
// N-direction traffic-light controller. Directions are served one at a time
// through GREEN -> YELLOW -> ALLRED. In actuated mode directions without
// demand are skipped and the current green rests until another direction
// asks for service. A flash request diverts the ALLRED exit into a
// flashing-yellow mode for all directions.
//
// Ports:
//   clk       in  1           clock
//   rst       in  1           asynchronous active-low reset
//   req       in  NUM_DIR     per-direction request (level or pulse)
//   flash     in  1           request flashing-yellow mode (level)
//   lights    out 3*NUM_DIR   lamp code of direction i on [3i+2:3i]
//   phase     out clog2(N)    direction currently owning right-of-way
//   in_flash  out 1           controller is in FLASH
// ---------------------------------------------------------------------------
module tlc_multi
  import tlc_pkg::*;
#(
  parameter  int NUM_DIR  = 4,
  parameter  int CNT_W    = 6,
  parameter  int GREEN_T  = 15,
  parameter  int YELLOW_T = 3,
  parameter  int ALLRED_T = 3,
  parameter  int FLASH_T  = 8,
  parameter  int ACTUATED = 1,
  localparam int PH_W     = $clog2(NUM_DIR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DIR-1:0]     req,
  input  logic                   flash,
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [PH_W-1:0]        phase,
  output logic                   in_flash
);

  // Timer load values: a state of duration D runs the timer D-1 .. 0.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
  localparam logic [PH_W-1:0]  PH_RST    = PH_W'(NUM_DIR - 1);

  tlc_state_e          state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [NUM_DIR-1:0]  dem_q,   dem_d;
  logic                fbit_q,  fbit_d;   // 0 = yellow half, 1 = dark half

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_zero;

  logic [NUM_DIR-1:0]  own_mask;   // one-hot of current phase
  logic [NUM_DIR-1:0]  nxt_mask;   // one-hot of next phase
  logic [NUM_DIR-1:0]  other_dem;  // service wanted by someone else
  logic [NUM_DIR-1:0]  dem_clr;
  logic [MAX_DIR-1:0]  dem_ext;
  logic [PH_W-1:0]     rr_sel;

  // -------------------------------------------------------------------------
  // State timer
  // -------------------------------------------------------------------------
  tlc_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // -------------------------------------------------------------------------
  // Phase decode masks
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_mask
      assign own_mask[gi] = (phase_q == PH_W'(gi));
      assign nxt_mask[gi] = (phase_d == PH_W'(gi));
    end
  endgenerate

  // Pending requests are included so a resting green yields on the same edge
  // that first sees another direction's request.
  assign other_dem = (dem_q | req) & ~own_mask;

  // Next-direction choice; fixed-time mode searches an empty demand vector,
  // which degenerates to phase+1 with wrap.
  always_comb begin
    dem_ext                = '0;
    dem_ext[NUM_DIR-1:0]   = dem_q;
    if (ACTUATED == 0) begin
      dem_ext = '0;
    end
    rr_sel = PH_W'(rr_next(dem_ext, 3'(phase_q), NUM_DIR));
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ALLRED;
      phase_q <= PH_RST;
      dem_q   <= '0;
      fbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dem_q   <= dem_d;
      fbit_q  <= fbit_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    fbit_d   = fbit_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      GREEN: begin
        // Flash cuts green short; otherwise leave at expiry unless resting.
        if (flash || (tmr_zero && ((ACTUATED == 0) || (|other_dem)))) begin
          state_d  = YELLOW;
          tmr_load = 1'b1;
          tmr_val  = YELLOW_LD;
        end
      end
      YELLOW: begin
        if (tmr_zero) begin
          state_d  = ALLRED;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
        end
      end
      ALLRED: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (flash) begin
            state_d = FLASH;
            fbit_d  = 1'b0;
            tmr_val = FLASH_LD;
          end else begin
            state_d = GREEN;
            phase_d = rr_sel;
            tmr_val = GREEN_LD;
          end
        end
      end
      FLASH: begin
        if (!flash) begin
          state_d  = ALLRED;
          tmr_load = 1'b1;
          tmr_val  = ALLRED_LD;
        end else if (tmr_zero) begin
          fbit_d   = ~fbit_q;
          tmr_load = 1'b1;
          tmr_val  = FLASH_LD;
        end
      end
      default: begin
        state_d  = ALLRED;
        tmr_load = 1'b1;
        tmr_val  = ALLRED_LD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Demand latch. The green direction is cleared both while it is green and
  // on the edge that grants it green, so a request arriving exactly at
  // grant time is absorbed by the grant.
  // -------------------------------------------------------------------------
  always_comb begin
    dem_clr = '0;
    if (state_q == GREEN) begin
      dem_clr = dem_clr | own_mask;
    end
    if (state_d == GREEN) begin
      dem_clr = dem_clr | nxt_mask;
    end
    dem_d = (dem_q | req) & ~dem_clr;
  end

  // -------------------------------------------------------------------------
  // Output decode from registered state only
  // -------------------------------------------------------------------------
  always_comb begin
    lights   = '0;
    in_flash = (state_q == FLASH);
    for (int i = 0; i < NUM_DIR; i++) begin
      logic [2:0] lamp;
      lamp = LAMP_RED;
      unique case (state_q)
        GREEN:   if (own_mask[i]) lamp = LAMP_GRN;
        YELLOW:  if (own_mask[i]) lamp = LAMP_YEL;
        FLASH:   lamp = fbit_q ? LAMP_OFF : LAMP_YEL;
        default: lamp = LAMP_RED;
      endcase
      lights[3*i +: 3] = lamp;
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_tlc_multi.sv
`timescale 1ns/1ps
module tb_tlc_multi;

  // Lamp words for 4 directions, {dir3, dir2, dir1, dir0}
  localparam logic [11:0] RR = 12'h924;
  localparam logic [11:0] G0 = 12'h921;
  localparam logic [11:0] Y0 = 12'h922;
  localparam logic [11:0] G1 = 12'h90C;
  localparam logic [11:0] Y1 = 12'h914;
  localparam logic [11:0] G2 = 12'h864;
  localparam logic [11:0] Y2 = 12'h8A4;
  localparam logic [11:0] G3 = 12'h324;
  localparam logic [11:0] Y3 = 12'h524;
  localparam logic [11:0] FY = 12'h492;
  localparam logic [11:0] FO = 12'h000;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic [3:0]  req     = '0;
  logic        flash   = 1'b0;
  logic [3:0]  req_f   = '0;
  logic        flash_f = 1'b0;

  logic [11:0] lights_a, lights_f;
  logic [1:0]  phase_a,  phase_f;
  logic        in_flash_a, in_flash_f;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tlc_multi #(
    .NUM_DIR(4), .CNT_W(6), .GREEN_T(5), .YELLOW_T(2),
    .ALLRED_T(1), .FLASH_T(3), .ACTUATED(1)
  ) dut_a (
    .clk(clk), .rst(rst), .req(req), .flash(flash),
    .lights(lights_a), .phase(phase_a), .in_flash(in_flash_a)
  );

  tlc_multi #(
    .NUM_DIR(4), .CNT_W(6), .GREEN_T(5), .YELLOW_T(2),
    .ALLRED_T(1), .FLASH_T(3), .ACTUATED(0)
  ) dut_f (
    .clk(clk), .rst(rst), .req(req_f), .flash(flash_f),
    .lights(lights_f), .phase(phase_f), .in_flash(in_flash_f)
  );

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle lamp safety: at most one non-red lamp, or all yellow/dark
  // while flashing.
  task automatic safety(input string name, input logic [11:0] l,
                        input logic fl);
    int nonred;
    logic ok;
    nonred = 0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (l[3*i +: 3] != 3'b100) nonred++;
      if (fl && !(l[3*i +: 3] == 3'b010 || l[3*i +: 3] == 3'b000)) ok = 1'b0;
    end
    if (!fl && nonred > 1) ok = 1'b0;
    check(name, {15'd0, ok}, 16'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      safety("safety_act", lights_a, in_flash_a);
      safety("safety_fix", lights_f, in_flash_f);
    end
  end

  // Table of {inputs before an edge, outputs expected after it, repeat}
  typedef struct {
    string       name;
    logic [3:0]  req;
    logic        flash;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic        in_fl;
    int          n;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic [3:0] r,
                              input logic f, input logic [11:0] l,
                              input logic [1:0] p, input logic fl,
                              input int n);
    vec_t v;
    v.name = name; v.req = r; v.flash = f; v.lights = l;
    v.phase = p; v.in_fl = fl; v.n = n;
    vecs.push_back(v);
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      for (int r = 0; r < vecs[i].n; r++) begin
        req   = vecs[i].req;
        flash = vecs[i].flash;
        @(posedge clk); #1;
        $display("row %s[%0d] req=%b flash=%b lights=%h phase=%0d in_flash=%b",
                 vecs[i].name, r, req, flash, lights_a, phase_a, in_flash_a);
        check($sformatf("%s[%0d]", vecs[i].name, r),
              {1'b0, lights_a, phase_a, in_flash_a},
              {1'b0, vecs[i].lights, vecs[i].phase, vecs[i].in_fl});
      end
    end
    req = '0;
  endtask

  // Fixed-time instance: 8-cycle slot per direction (G5, Y2, R1).
  initial begin : fixed_chk
    int dir;
    int pos;
    logic [11:0] exp;
    @(posedge rst);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      dir = ((k - 1) / 8) % 4;
      pos = (k - 1) % 8;
      exp = RR;
      if (pos < 5)      exp[3*dir +: 3] = 3'b001;
      else if (pos < 7) exp[3*dir +: 3] = 3'b010;
      $display("fixed k=%0d lights=%h phase=%0d", k, lights_f, phase_f);
      check($sformatf("fixed_k%0d", k), {2'b00, lights_f, phase_f},
            {2'b00, exp, 2'(dir)});
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int seg_b;

    // Part A: reset release, rest, skip, flash
    add("s1_rest",   4'b0000, 1'b0, G0, 2'd0, 1'b0, 10);
    add("s3_pulse",  4'b0100, 1'b0, Y0, 2'd0, 1'b0, 1);
    add("s3_yel",    4'b0000, 1'b0, Y0, 2'd0, 1'b0, 1);
    add("s3_red",    4'b0000, 1'b0, RR, 2'd0, 1'b0, 1);
    add("s3_g2",     4'b0000, 1'b0, G2, 2'd2, 1'b0, 8);
    add("s5_pulse",  4'b0010, 1'b0, Y2, 2'd2, 1'b0, 1);
    add("s5_yel",    4'b0000, 1'b0, Y2, 2'd2, 1'b0, 1);
    add("s5_red",    4'b0000, 1'b0, RR, 2'd2, 1'b0, 1);
    add("s5_g1",     4'b0000, 1'b0, G1, 2'd1, 1'b0, 2);
    add("s5_fl_yel", 4'b0000, 1'b1, Y1, 2'd1, 1'b0, 2);
    add("s5_fl_red", 4'b0000, 1'b1, RR, 2'd1, 1'b0, 1);
    add("s5_fy0",    4'b0000, 1'b1, FY, 2'd1, 1'b1, 3);
    add("s5_fo0",    4'b0000, 1'b1, FO, 2'd1, 1'b1, 3);
    add("s5_fy_req", 4'b1000, 1'b1, FY, 2'd1, 1'b1, 1);
    add("s5_fy1",    4'b0000, 1'b1, FY, 2'd1, 1'b1, 2);
    add("s5_fo1",    4'b0000, 1'b1, FO, 2'd1, 1'b1, 1);
    add("s5_drop",   4'b0000, 1'b0, RR, 2'd1, 1'b0, 1);
    add("s5_g3",     4'b0000, 1'b0, G3, 2'd3, 1'b0, 6);
    add("s6_pulse",  4'b0001, 1'b0, Y3, 2'd3, 1'b0, 1);
    seg_b = vecs.size();
    // Part B: after mid-yellow reset, then two simultaneous requests
    add("s6_g0",     4'b0000, 1'b0, G0, 2'd0, 1'b0, 1);
    add("s4_pulse",  4'b1010, 1'b0, G0, 2'd0, 1'b0, 1);
    add("s4_g0",     4'b0000, 1'b0, G0, 2'd0, 1'b0, 3);
    add("s4_y0",     4'b0000, 1'b0, Y0, 2'd0, 1'b0, 2);
    add("s4_r0",     4'b0000, 1'b0, RR, 2'd0, 1'b0, 1);
    add("s4_g1",     4'b0000, 1'b0, G1, 2'd1, 1'b0, 5);
    add("s4_y1",     4'b0000, 1'b0, Y1, 2'd1, 1'b0, 2);
    add("s4_r1",     4'b0000, 1'b0, RR, 2'd1, 1'b0, 1);
    add("s4_g3",     4'b0000, 1'b0, G3, 2'd3, 1'b0, 7);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    $display("reset lights=%h phase=%0d in_flash=%b", lights_a, phase_a, in_flash_a);
    check("reset_act", {1'b0, lights_a, phase_a, in_flash_a}, {1'b0, RR, 2'd3, 1'b0});
    check("reset_fix", {1'b0, lights_f, phase_f, in_flash_f}, {1'b0, RR, 2'd3, 1'b0});
    rst = 1'b1;
    #1;
    $display("release lights=%h phase=%0d", lights_a, phase_a);
    check("release_red", {1'b0, lights_a, phase_a, in_flash_a}, {1'b0, RR, 2'd3, 1'b0});

    run_rows(0, seg_b);

    // Mid-yellow asynchronous reset
    #3;
    rst = 1'b0;
    #1;
    $display("async_rst lights=%h phase=%0d in_flash=%b", lights_a, phase_a, in_flash_a);
    check("async_rst", {1'b0, lights_a, phase_a, in_flash_a}, {1'b0, RR, 2'd3, 1'b0});
    @(posedge clk); #1;
    check("rst_hold", {1'b0, lights_a, phase_a, in_flash_a}, {1'b0, RR, 2'd3, 1'b0});
    rst = 1'b1;
    #1;
    $display("re_release lights=%h phase=%0d", lights_a, phase_a);
    check("re_release", {1'b0, lights_a, phase_a, in_flash_a}, {1'b0, RR, 2'd3, 1'b0});

    run_rows(seg_b, vecs.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
